// File: rtl/i2s_audio_tx.sv
// Philips I2S transmitter with a single-entry sample hold register, BCLK/LRCK divided
// from AUDIO_CLK, and underrun/overrun pulses for sample-rate bring-up.
module i2s_audio_tx #(
    parameter int unsigned AUD_BIT_DEPTH = 24,
    parameter int unsigned SLOT_BITS     = 32,
    parameter int unsigned BCLK_DIV      = 4
) (
    input  logic                     AUDIO_CLK,
    input  logic                     reset_reg,
    input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
    input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic                     bclk,
    output logic                     lrck,
    output logic                     sdata,
    output logic                     frame_start,
    output logic                     underrun,
    output logic                     overrun
);

    localparam int unsigned DIV_W    = $clog2(BCLK_DIV);
    localparam int unsigned BIT_W    = $clog2(2 * SLOT_BITS);
    localparam int unsigned POS_W    = $clog2(SLOT_BITS);
    localparam int unsigned DIV_HALF = BCLK_DIV / 2;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_MID   = DIV_W'(DIV_HALF);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_SIZE = BIT_W'(SLOT_BITS);
    localparam logic [POS_W-1:0] POS_MSB   = POS_W'(1);
    localparam logic [POS_W-1:0] POS_LSB   = POS_W'(AUD_BIT_DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DIV_W-1:0] div_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [BIT_W-1:0] bit_nxt;
    logic             div_wrap;
    logic             tick;

    logic             slot_sel;
    logic [POS_W-1:0] slot_pos;
    logic [POS_W-1:0] bit_idx;
    logic             ser_bit;

    logic                     hold_full;
    logic [AUD_BIT_DEPTH-1:0] hold_l;
    logic [AUD_BIT_DEPTH-1:0] hold_r;
    logic [AUD_BIT_DEPTH-1:0] shift_l;
    logic [AUD_BIT_DEPTH-1:0] shift_r;
    logic [AUD_BIT_DEPTH-1:0] last_l;
    logic [AUD_BIT_DEPTH-1:0] last_r;

    // Control state register
    always_ff @(posedge AUDIO_CLK) begin
        if (reset_reg) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave IDLE on the first captured sample, then run until reset
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sample_valid) state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // Divider / bit counter next values and frame tick detection
    always_comb begin
        tick     = (state == RUN) && (div_cnt == '0) && (bit_cnt == '0);
        div_wrap = (div_cnt == DIV_LAST);
        div_nxt  = div_wrap ? '0 : div_cnt + DIV_W'(1);
        bit_nxt  = bit_cnt;
        if (div_wrap) begin
            bit_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
        end
    end

    // Slot decode and serial bit select: MSB one BCLK after the slot edge, zero pad after LSB
    always_comb begin
        slot_sel = (bit_cnt >= SLOT_SIZE);
        slot_pos = slot_sel ? POS_W'(bit_cnt - SLOT_SIZE) : POS_W'(bit_cnt);
        bit_idx  = POS_LSB - slot_pos;
        ser_bit  = 1'b0;
        if ((slot_pos >= POS_MSB) && (slot_pos <= POS_LSB)) begin
            ser_bit = slot_sel ? shift_r[bit_idx] : shift_l[bit_idx];
        end
    end

    // Bit clock generation and serial outputs, updated only at the BCLK falling edge
    always_ff @(posedge AUDIO_CLK) begin
        if (reset_reg) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            bclk    <= 1'b0;
            lrck    <= 1'b0;
            sdata   <= 1'b0;
        end else if (state == RUN) begin
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            bclk    <= (div_nxt >= DIV_MID);
            if (div_cnt == '0) begin
                lrck  <= slot_sel;
                sdata <= ser_bit;
            end
        end
    end

    // Hold register, frame transfer into the shifters, and status pulses
    always_ff @(posedge AUDIO_CLK) begin
        if (reset_reg) begin
            hold_full    <= 1'b0;
            sample_ready <= 1'b1;
            hold_l       <= '0;
            hold_r       <= '0;
            shift_l      <= '0;
            shift_r      <= '0;
            last_l       <= '0;
            last_r       <= '0;
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            frame_start <= tick;
            underrun    <= tick && !hold_full;
            // A strobe landing on the tick refills the slot just drained, so it is not an overrun
            overrun     <= sample_valid && hold_full && !tick;

            if (tick) begin
                if (hold_full) begin
                    shift_l <= hold_l;
                    shift_r <= hold_r;
                    last_l  <= hold_l;
                    last_r  <= hold_r;
                end else begin
                    shift_l <= last_l;
                    shift_r <= last_r;
                end
            end

            if (sample_valid) begin
                hold_l       <= lsound_in;
                hold_r       <= rsound_in;
                hold_full    <= 1'b1;
                sample_ready <= 1'b0;
            end else if (tick) begin
                hold_full    <= 1'b0;
                sample_ready <= 1'b1;
            end
        end
    end

endmodule
